dynode_evt_sched: RTL

- Collects timestamped events from NCH dynode_eventdet channels and merges them into one event stream using a valid/ready handshake.
- Each channel has a one-entry pending slot. Pending slots are drained round-robin into a single output register.
- Losses and pileup dumps are counted per channel.
- A run/drain FSM gates capture, so the downstream coincidence logic can flush cleanly between acquisitions.

---
 rtl/dynode_pkg.sv | 25 ++
 rtl/rr_arbiter_nch.sv | 30 +++
 rtl/dynode_evt_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dynode_pkg.sv
// Shared types and helpers for the dynode event scheduler.
package dynode_pkg;

    localparam int DYN_TW = 24;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_RUN   = 2'd1,
        SCH_DRAIN = 2'd2
    } sch_state_t;

    typedef struct packed {
        logic [DYN_TW-1:0] tstamp;
        logic              pileup;
        logic [2:0]        chan;
    } dyn_evt_t;

    // Channel index reached by stepping 'off' places above 'base', modulo n.
    function automatic int unsigned rr_wrap(input logic [2:0] base,
                                            input int unsigned off,
                                            input int unsigned n);
        return (32'(base) + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter_nch.sv
// Round-robin arbiter: picks the first requester searching upward from last_grant+1.
module rr_arbiter_nch
    import dynode_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] req,
    input  logic [2:0]     last_grant,
    output logic [NCH-1:0] gnt_onehot,
    output logic [2:0]     gnt_idx,
    output logic           any
);

    // Scan offsets 1..NCH; the first offset that lands on a requester wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int unsigned off = 1; off <= NCH; off++) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!any && req[i] && (i == rr_wrap(last_grant, off, NCH))) begin
                    any           = 1'b1;
                    gnt_onehot[i] = 1'b1;
                    gnt_idx       = 3'(i);
                end
            end
        end
    end

endmodule

// File: rtl/dynode_evt_sched.sv
// Merges per-channel dynode events into one valid/ready stream with
// per-channel pending slots, loss/pileup-dump counters and a run/drain FSM.
module dynode_evt_sched
    import dynode_pkg::*;
#(
    parameter int NCH = 4,
    parameter int TW  = DYN_TW,
    parameter int CW  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic [NCH-1:0]    chan_en,
    input  logic [NCH-1:0]    dyn_event,
    input  logic [NCH-1:0]    dyn_pileup,
    input  logic [NCH-1:0]    dyn_pudump,
    input  logic [NCH*TW-1:0] evntim,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [2:0]        ev_chan,
    output logic [TW-1:0]     ev_time,
    output logic              ev_pileup,
    input  logic              clr_stat,
    output logic [NCH*CW-1:0] lost_cnt,
    output logic [NCH*CW-1:0] pudump_cnt,
    output logic              lost_any,
    output logic              busy,
    output logic              drained
);

    sch_state_t state, state_nxt;
    logic       drain_done;

    logic [NCH-1:0][TW-1:0] evt_time_in;
    logic [NCH-1:0]         pend;
    logic [NCH-1:0][TW-1:0] slot_time;
    logic [NCH-1:0]         slot_pu;
    logic [2:0]             last_grant;

    logic [NCH-1:0] gnt_onehot;
    logic [2:0]     gnt_idx;
    logic           gnt_any;
    logic           out_free;
    logic           grant;
    logic [NCH-1:0] gnt_eff;
    logic [TW-1:0]  gnt_time;
    logic           gnt_pu;

    logic [NCH-1:0] cap_hit;
    logic [NCH-1:0] cap_load;
    logic [NCH-1:0] cap_drop;
    logic           count_on;

    logic [NCH-1:0][CW-1:0] lost_q;
    logic [NCH-1:0][CW-1:0] pud_q;

    assign evt_time_in = evntim;
    assign lost_cnt    = lost_q;
    assign pudump_cnt  = pud_q;

    rr_arbiter_nch #(
        .NCH (NCH)
    ) u_arb (
        .req        (pend),
        .last_grant (last_grant),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign out_free = !ev_valid || ev_ready;
    assign grant    = out_free && gnt_any;
    assign gnt_eff  = grant ? gnt_onehot : '0;
    assign count_on = (state != SCH_IDLE);

    // A granted slot is vacated this cycle, so a same-cycle arrival refills it instead of dropping.
    always_comb begin
        cap_hit  = (state == SCH_RUN) ? (dyn_event & chan_en) : '0;
        cap_load = cap_hit & (~pend | gnt_eff);
        cap_drop = cap_hit & pend & ~gnt_eff;
    end

    // One-hot mux of the granted slot contents.
    always_comb begin
        gnt_time = '0;
        gnt_pu   = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt_onehot[i]) begin
                gnt_time = gnt_time | slot_time[i];
                gnt_pu   = gnt_pu | slot_pu[i];
            end
        end
    end

    // Per-channel pending slots: load on capture, vacate on grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= '0;
            slot_time <= '0;
            slot_pu   <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cap_load[i]) begin
                    pend[i]      <= 1'b1;
                    slot_time[i] <= evt_time_in[i];
                    slot_pu[i]   <= dyn_pileup[i];
                end else if (gnt_eff[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer; fields hold while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_valid   <= 1'b0;
            ev_chan    <= '0;
            ev_time    <= '0;
            ev_pileup  <= 1'b0;
            last_grant <= 3'(NCH-1);
        end else if (grant) begin
            ev_valid   <= 1'b1;
            ev_chan    <= gnt_idx;
            ev_time    <= gnt_time;
            ev_pileup  <= gnt_pu;
            last_grant <= gnt_idx;
        end else if (out_free) begin
            ev_valid <= 1'b0;
        end
    end

    // Saturating loss and pileup-dump counters; clear wins over increments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lost_q   <= '0;
            pud_q    <= '0;
            lost_any <= 1'b0;
        end else if (clr_stat) begin
            lost_q   <= '0;
            pud_q    <= '0;
            lost_any <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cap_drop[i] && (lost_q[i] != '1)) begin
                    lost_q[i] <= lost_q[i] + CW'(1);
                end
                if (count_on && dyn_pudump[i] && (pud_q[i] != '1)) begin
                    pud_q[i] <= pud_q[i] + CW'(1);
                end
            end
            if (|cap_drop) begin
                lost_any <= 1'b1;
            end
        end
    end

    // FSM state register with registered busy and drained pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= SCH_IDLE;
            busy    <= 1'b0;
            drained <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != SCH_IDLE);
            drained <= drain_done;
        end
    end

    // Next-state logic: drain completes once no slot is pending and the output can retire.
    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        case (state)
            SCH_IDLE: begin
                if (run) state_nxt = SCH_RUN;
            end
            SCH_RUN: begin
                if (!run) state_nxt = SCH_DRAIN;
            end
            SCH_DRAIN: begin
                if (run) begin
                    state_nxt = SCH_RUN;
                end else if (!(|pend) && out_free) begin
                    state_nxt  = SCH_IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_nxt = SCH_IDLE;
        endcase
    end

endmodule
